mac_seq: RTL and testbench

MAC_SEQ -- requirements
Module: mac_seq

---
 rtl/mac_seq.sv | 170 +++++++++++++++++
 tb/tb_mac_seq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq.sv
// mac_seq: control sequencer for a single-MAC FIR datapath.
//
// For every accepted sample the sequencer loads the shift register, steps
// the shared ROM/shift-register address through NUM_TAPS taps while the
// accumulator runs, loads the output register and then holds the result
// until downstream takes it. A sample that arrives while a computation is
// in flight (or while an unconsumed result is held) is dropped. A dropped
// sample does not disturb the running computation. Instead it raises the
// sticky overrun flag.
//
// Optional feature, selected by the macro MAC_SEQ_OVR_CNT_EN:
//   defined   -> ovr_count is an 8-bit saturating count of dropped samples
//   undefined -> ovr_count is tied to zero and no counter is built
//
// Every control output is decoded from the registered state and the
// registered tap counter only. Inputs never reach outputs through
// combinational paths.

module mac_seq #(
    parameter int NUM_TAPS   = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sample_valid,
    input  logic                  out_ready,
    input  logic                  ovr_clr,
    output logic                  shift_en,
    output logic [ADDR_WIDTH-1:0] tap_addr,
    output logic                  acc_clr,
    output logic                  acc_en,
    output logic                  result_load,
    output logic                  result_valid,
    output logic                  busy,
    output logic                  overrun,
    output logic [7:0]            ovr_count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        MAC   = 3'd2,
        FLUSH = 3'd3,
        HOLD  = 3'd4
    } state_t;

    // The address of the final tap. MAC hands over to FLUSH after this tap.
    localparam logic [ADDR_WIDTH-1:0] LAST_TAP = ADDR_WIDTH'(NUM_TAPS - 1);

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] tap_q;
    logic [ADDR_WIDTH-1:0] tap_next;
    logic                  drop;
    logic                  overrun_q;

    // State register and tap counter. Reset parks the sequencer in IDLE at tap 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            tap_q <= '0;
        end else begin
            state <= state_next;
            tap_q <= tap_next;
        end
    end

    // Next-state and next-tap logic. The tap counter is zero outside MAC.
    always_comb begin
        state_next = state;
        tap_next   = '0;
        case (state)
            IDLE: begin
                if (sample_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                state_next = MAC;
            end
            MAC: begin
                if (tap_q == LAST_TAP) begin
                    state_next = FLUSH;
                end else begin
                    tap_next = tap_q + 1'b1;
                end
            end
            FLUSH: begin
                state_next = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    state_next = sample_valid ? SHIFT : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath controls decoded purely from the registered state and tap counter.
    always_comb begin
        shift_en     = 1'b0;
        acc_en       = 1'b0;
        acc_clr      = 1'b0;
        result_load  = 1'b0;
        result_valid = 1'b0;
        busy         = (state != IDLE);
        case (state)
            SHIFT: shift_en = 1'b1;
            MAC: begin
                acc_en  = 1'b1;
                acc_clr = (tap_q == '0);
            end
            FLUSH:   result_load  = 1'b1;
            HOLD:    result_valid = 1'b1;
            default: begin
            end
        endcase
    end

    assign tap_addr = tap_q;

    // A sample is dropped when it arrives while the sequencer cannot take it.
    // HOLD takes a sample only in the same cycle that the result is consumed.
    always_comb begin
        drop = 1'b0;
        if (sample_valid) begin
            case (state)
                SHIFT, MAC, FLUSH: drop = 1'b1;
                HOLD:              drop = !out_ready;
                default:           drop = 1'b0;
            endcase
        end
    end

    // Sticky overrun flag. A drop in the same cycle as a clear wins, so the flag is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else if (drop) begin
            overrun_q <= 1'b1;
        end else if (ovr_clr) begin
            overrun_q <= 1'b0;
        end
    end

    assign overrun = overrun_q;

`ifdef MAC_SEQ_OVR_CNT_EN
    logic [7:0] ovr_count_q;

    // Saturating drop counter. A clear together with a drop restarts the count at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_count_q <= 8'd0;
        end else if (ovr_clr) begin
            ovr_count_q <= drop ? 8'd1 : 8'd0;
        end else if (drop && (ovr_count_q != 8'd255)) begin
            ovr_count_q <= ovr_count_q + 8'd1;
        end
    end

    assign ovr_count = ovr_count_q;
`else
    assign ovr_count = 8'd0;
`endif

endmodule

// File: tb/tb_mac_seq.sv
// tb_mac_seq: directed testbench for mac_seq with default parameters
// (NUM_TAPS=4, ADDR_WIDTH=2). The expected ovr_count values follow the
// MAC_SEQ_OVR_CNT_EN macro. With the macro defined the counter is live.
// Without the macro the counter reads zero.
//
// Cycle numbering: "cycle n" is the interval after the n-th rising edge
// that follows the cycle in which sample_valid was driven high (cycle 0).
// Outputs are sampled 1 ns after each rising edge.

module tb_mac_seq;

    logic       clk;
    logic       rst_n;
    logic       sample_valid;
    logic       out_ready;
    logic       ovr_clr;
    logic       shift_en;
    logic [1:0] tap_addr;
    logic       acc_clr;
    logic       acc_en;
    logic       result_load;
    logic       result_valid;
    logic       busy;
    logic       overrun;
    logic [7:0] ovr_count;

    int checks = 0;
    int passes = 0;

`ifdef MAC_SEQ_OVR_CNT_EN
    localparam logic [7:0] CNT_ONE = 8'd1;
    localparam logic [7:0] CNT_254 = 8'd254;
    localparam logic [7:0] CNT_SAT = 8'd255;
`else
    localparam logic [7:0] CNT_ONE = 8'd0;
    localparam logic [7:0] CNT_254 = 8'd0;
    localparam logic [7:0] CNT_SAT = 8'd0;
`endif

    // Packed view of the sequencing outputs. The fields, from MSB to LSB, are
    // shift_en, acc_en, acc_clr, result_load, result_valid, busy, tap_addr.
    logic [7:0] obs;
    assign obs = {shift_en, acc_en, acc_clr, result_load, result_valid, busy, tap_addr};

    mac_seq #(
        .NUM_TAPS  (4),
        .ADDR_WIDTH(2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_valid(sample_valid),
        .out_ready   (out_ready),
        .ovr_clr     (ovr_clr),
        .shift_en    (shift_en),
        .tap_addr    (tap_addr),
        .acc_clr     (acc_clr),
        .acc_en      (acc_en),
        .result_load (result_load),
        .result_valid(result_valid),
        .busy        (busy),
        .overrun     (overrun),
        .ovr_count   (ovr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hand-derived expected timeline for one sample with out_ready held high.
    // Cycle 1 is SHIFT, cycles 2..5 are MAC at taps 0..3, cycle 6 is FLUSH,
    // cycle 7 is HOLD, and cycle 8 onwards is IDLE.
    function automatic logic [7:0] exp_vec(input int c);
        logic [1:0] t;
        logic       s, a, z, l, v, b;
        t = (c >= 2 && c <= 5) ? 2'(c - 2) : 2'd0;
        s = (c == 1);
        a = (c >= 2 && c <= 5);
        z = (c == 2);
        l = (c == 6);
        v = (c == 7);
        b = (c >= 1 && c <= 7);
        return {s, a, z, l, v, b, t};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (obs !== 8'h00) $display("[TB] FAIL reset_outputs: got %b, want %b", obs, 8'h00);
        else passes++;
        checks++;
        if ({overrun, ovr_count} !== 9'd0) $display("[TB] FAIL reset_overrun: got %b/%0d, want 0/0", overrun, ovr_count);
        else passes++;
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs !== 8'h00) $display("[TB] FAIL reset_idle_after_release: got %b, want %b", obs, 8'h00);
        else passes++;
    endtask

    task automatic test_single_sample(input string tag);
        out_ready    = 1'b1;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (obs !== exp_vec(c))
                $display("[TB] FAIL %s_cycle%0d: got %b, want %b", tag, c, obs, exp_vec(c));
            else passes++;
            tick();
        end
    endtask

    task automatic test_hold();
        out_ready    = 1'b0;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        for (int c = 2; c <= 7; c++) tick();
        checks++;
        if (obs !== exp_vec(7)) $display("[TB] FAIL hold_first_valid: got %b, want %b", obs, exp_vec(7));
        else passes++;
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if ({result_valid, busy} !== 2'b11)
                $display("[TB] FAIL hold_wait%0d: got valid/busy %b, want 11", i, {result_valid, busy});
            else passes++;
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (obs !== 8'h00) $display("[TB] FAIL hold_release: got %b, want %b", obs, 8'h00);
        else passes++;
        checks++;
        if (overrun !== 1'b0) $display("[TB] FAIL hold_no_overrun: got %b, want 0", overrun);
        else passes++;
    endtask

    task automatic test_back_to_back();
        out_ready    = 1'b0;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        for (int c = 2; c <= 7; c++) tick();
        out_ready    = 1'b1;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        checks++;
        if (obs !== exp_vec(1)) $display("[TB] FAIL b2b_shift: got %b, want %b", obs, exp_vec(1));
        else passes++;
        checks++;
        if (overrun !== 1'b0) $display("[TB] FAIL b2b_no_overrun: got %b, want 0", overrun);
        else passes++;
        for (int c = 2; c <= 8; c++) begin
            tick();
            checks++;
            if (obs !== exp_vec(c)) $display("[TB] FAIL b2b_cycle%0d: got %b, want %b", c, obs, exp_vec(c));
            else passes++;
        end
    endtask

    task automatic test_drop();
        ovr_clr = 1'b1;
        tick();
        ovr_clr   = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c <= 7; c++) begin
            sample_valid = (c == 0 || c == 3);
            tick();
            sample_valid = 1'b0;
            checks++;
            if (obs !== exp_vec(c + 1))
                $display("[TB] FAIL drop_cycle%0d: got %b, want %b", c + 1, obs, exp_vec(c + 1));
            else passes++;
            checks++;
            if (overrun !== (c + 1 >= 4))
                $display("[TB] FAIL drop_overrun%0d: got %b, want %b", c + 1, overrun, (c + 1 >= 4));
            else passes++;
        end
        checks++;
        if (ovr_count !== CNT_ONE) $display("[TB] FAIL drop_count: got %0d, want %0d", ovr_count, CNT_ONE);
        else passes++;
    endtask

    task automatic test_reset_mid();
        out_ready    = 1'b1;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        for (int c = 2; c <= 4; c++) tick();
        checks++;
        if (obs !== exp_vec(4)) $display("[TB] FAIL midrst_before: got %b, want %b", obs, exp_vec(4));
        else passes++;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 8'h00) $display("[TB] FAIL midrst_outputs: got %b, want %b", obs, 8'h00);
        else passes++;
        checks++;
        if ({overrun, ovr_count} !== 9'd0) $display("[TB] FAIL midrst_overrun: got %b/%0d, want 0/0", overrun, ovr_count);
        else passes++;
        #3 rst_n = 1'b1;
        tick();
        checks++;
        if (obs !== 8'h00) $display("[TB] FAIL midrst_idle: got %b, want %b", obs, 8'h00);
        else passes++;
        test_single_sample("postrst");
    endtask

    task automatic test_saturate();
        ovr_clr = 1'b1;
        tick();
        ovr_clr      = 1'b0;
        out_ready    = 1'b0;
        sample_valid = 1'b1;
        tick();
        for (int i = 0; i < 254; i++) tick();
        checks++;
        if (ovr_count !== CNT_254) $display("[TB] FAIL sat_count254: got %0d, want %0d", ovr_count, CNT_254);
        else passes++;
        for (int i = 0; i < 46; i++) tick();
        checks++;
        if (ovr_count !== CNT_SAT) $display("[TB] FAIL sat_count300: got %0d, want %0d", ovr_count, CNT_SAT);
        else passes++;
        checks++;
        if ({overrun, result_valid} !== 2'b11) $display("[TB] FAIL sat_flags: got %b, want 11", {overrun, result_valid});
        else passes++;
        ovr_clr = 1'b1;
        tick();
        checks++;
        if (ovr_count !== CNT_ONE) $display("[TB] FAIL sat_clr_drop_count: got %0d, want %0d", ovr_count, CNT_ONE);
        else passes++;
        checks++;
        if (overrun !== 1'b1) $display("[TB] FAIL sat_clr_drop_overrun: got %b, want 1", overrun);
        else passes++;
        sample_valid = 1'b0;
        tick();
        ovr_clr = 1'b0;
        checks++;
        if ({overrun, ovr_count} !== 9'd0) $display("[TB] FAIL sat_clear: got %b/%0d, want 0/0", overrun, ovr_count);
        else passes++;
        out_ready = 1'b1;
        tick();
        checks++;
        if (obs !== 8'h00) $display("[TB] FAIL sat_exit: got %b, want %b", obs, 8'h00);
        else passes++;
    endtask

    initial begin
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        out_ready    = 1'b0;
        ovr_clr      = 1'b0;
        #12;
        test_reset();
        test_single_sample("single");
        test_hold();
        test_back_to_back();
        test_drop();
        test_reset_mid();
        test_saturate();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
